prog_loader: RTL and testbench

- Upstream boot stage for the multi-cycle CPU.
- Receives a framed program image as a byte stream and assembles little-endian 32-bit words.
- Writes those words into the unified instruction/data memory through the same write port the CPU uses (address, write data, write strobe).
- Holds the CPU in reset until a complete, checksum-valid image has been loaded.

---
 rtl/prog_loader_if.sv | 29 ++
 rtl/prog_loader.sv | 140 ++++++++++++++
 tb/tb_prog_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream and memory write port bundle for prog_loader
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_write;
    logic [31:0] m_addr;
    logic [31:0] m_w_data;

    // loader side: consumes bytes, drives the memory write port
    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_write,
        output m_addr,
        output m_w_data
    );

    // byte source / memory side
    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_write,
        input  m_addr,
        input  m_w_data
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed boot image loader into CPU memory; optional inter-byte timeout under PROG_LOADER_TIMEOUT_EN
module prog_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [15:0]  word_count
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state, state_n;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [7:0]  csum;
    logic [1:0]  idx;
    logic        acc;
    logic        enter_len0;
    logic        tmo;

    assign acc        = bus.rx_valid && bus.rx_ready;
    assign enter_len0 = (state_n == LEN0) && (state != LEN0);
    assign len_full   = {bus.rx_data, len[7:0]};

`ifdef PROG_LOADER_TIMEOUT_EN
    logic [31:0] tcnt;
    logic        stall_state;

    assign stall_state = (state == LEN1) || (state == DATA) || (state == CSUM);
    // the stalled cycle that would bring the count to the limit is the one that aborts
    assign tmo = stall_state && !acc && (tcnt >= 32'(TIMEOUT_CYCLES - 1));

    // inter-byte idle counter, restarted by every accepted byte and every new load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= 32'd0;
        end else if (acc || enter_len0) begin
            tcnt <= 32'd0;
        end else if (stall_state) begin
            tcnt <= tcnt + 32'd1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state decode; start is only honoured when no load is in flight
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_n = LEN0;
            LEN0:            if (acc) state_n = LEN1;
            LEN1: begin
                if (acc) begin
                    if ({1'b0, len_full} > MAX_W) state_n = ERR;
                    else if (len_full == 16'd0)   state_n = CSUM;
                    else                          state_n = DATA;
                end
            end
            DATA:            if (acc && idx == 2'd3) state_n = WRITE;
            WRITE:           state_n = (word_count + 16'd1 == len) ? CSUM : DATA;
            CSUM:            if (acc) state_n = (bus.rx_data == csum) ? DONE : ERR;
            default:         state_n = IDLE;
        endcase
        if (tmo) state_n = ERR;
    end

    // registered control outputs decoded from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rx_ready  <= 1'b0;
            bus.mem_write <= 1'b0;
            cpu_rst       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            bus.rx_ready  <= (state_n == LEN0) || (state_n == LEN1) ||
                             (state_n == DATA) || (state_n == CSUM);
            bus.mem_write <= (state_n == WRITE);
            cpu_rst       <= (state_n != DONE);
            busy          <= (state_n == LEN0) || (state_n == LEN1) || (state_n == DATA) ||
                             (state_n == WRITE) || (state_n == CSUM);
            done          <= (state_n == DONE);
            err           <= (state_n == ERR);
        end
    end

    // length capture, word assembly, checksum and address/count advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.m_addr   <= BASE_ADDR;
            bus.m_w_data <= 32'd0;
            word_count   <= 16'd0;
            len          <= 16'd0;
            csum         <= 8'd0;
            idx          <= 2'd0;
        end else if (enter_len0) begin
            bus.m_addr <= BASE_ADDR;
            word_count <= 16'd0;
            csum       <= 8'd0;
            idx        <= 2'd0;
        end else begin
            case (state)
                LEN0: if (acc) len[7:0]  <= bus.rx_data;
                LEN1: if (acc) len[15:8] <= bus.rx_data;
                DATA: begin
                    if (acc) begin
                        bus.m_w_data[{idx, 3'b000} +: 8] <= bus.rx_data;
                        csum <= csum ^ bus.rx_data;
                        idx  <= idx + 2'd1;
                    end
                end
                WRITE: begin
                    word_count <= word_count + 16'd1;
                    bus.m_addr <= bus.m_addr + 32'd4;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven frame vectors plus reset/restart/timeout sequences for prog_loader
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cpu_rst, busy, done, err;
    logic [15:0] word_count;

    prog_loader_if bus();

    prog_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(256),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .cpu_rst(cpu_rst),
        .busy(busy),
        .done(done),
        .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nb;
        logic [95:0] b;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_wc;
        int          exp_nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic        prev_mw = 1'b0;
    vec_t        v[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_write) begin
            wa.push_back(bus.m_addr);
            wd.push_back(bus.m_w_data);
            chk("rx_ready_low_in_write", {31'd0, bus.rx_ready}, 32'd0);
            chk("mem_write_single_cycle", {31'd0, prev_mw}, 32'd0);
        end
        prev_mw = bus.mem_write;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"},  {31'd0, bus.rx_ready},  32'd0);
        chk({tag, "_mem_write"}, {31'd0, bus.mem_write}, 32'd0);
        chk({tag, "_m_addr"},    bus.m_addr,             32'h0);
        chk({tag, "_m_w_data"},  bus.m_w_data,           32'h0);
        chk({tag, "_cpu_rst"},   {31'd0, cpu_rst},       32'd1);
        chk({tag, "_busy"},      {31'd0, busy},          32'd0);
        chk({tag, "_done"},      {31'd0, done},          32'd0);
        chk({tag, "_err"},       {31'd0, err},           32'd0);
        chk({tag, "_wc"},        {16'd0, word_count},    32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // presents one byte with rx_valid held high until the loader takes it
    task automatic send(input logic [7:0] b);
        logic got;
        got = 1'b0;
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            got = bus.rx_ready;
            @(negedge clk);
        end
        if (!got) chk("send_byte_accept", 32'd0, 32'd1);
    endtask

    task automatic wait_end();
        for (int i = 0; i < 40; i++) begin
            if (done || err) break;
            @(negedge clk);
        end
        chk("load_finished", {31'd0, done | err}, 32'd1);
    endtask

    initial begin
        v[0] = '{nb: 11, b: 96'h0200_7856_3412_EFBE_ADDE_2A00, exp_done: 1'b1, exp_err: 1'b0,
                 exp_wc: 16'd2, exp_nw: 2, w0: 32'h1234_5678, w1: 32'hDEAD_BEEF};
        v[1] = '{nb: 11, b: 96'h0200_7856_3412_EFBE_ADDE_0000, exp_done: 1'b0, exp_err: 1'b1,
                 exp_wc: 16'd2, exp_nw: 2, w0: 32'h1234_5678, w1: 32'hDEAD_BEEF};
        v[2] = '{nb: 2,  b: {16'h0101, 80'h0},                 exp_done: 1'b0, exp_err: 1'b1,
                 exp_wc: 16'd0, exp_nw: 0, w0: 32'h0, w1: 32'h0};
        v[3] = '{nb: 3,  b: {24'h000000, 72'h0},               exp_done: 1'b1, exp_err: 1'b0,
                 exp_wc: 16'd0, exp_nw: 0, w0: 32'h0, w1: 32'h0};
        v[4] = '{nb: 3,  b: {24'h000055, 72'h0},               exp_done: 1'b0, exp_err: 1'b1,
                 exp_wc: 16'd0, exp_nw: 0, w0: 32'h0, w1: 32'h0};
        v[5] = '{nb: 7,  b: {56'h0100_1122_3344_44, 40'h0},    exp_done: 1'b1, exp_err: 1'b0,
                 exp_wc: 16'd1, exp_nw: 1, w0: 32'h4433_2211, w1: 32'h0};

        // asynchronous reset values before any clocked activity settles
        rst = 1'b0;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        @(negedge clk);
        chk_reset_vals("reset");

        for (int k = 0; k < 6; k++) begin
            do_reset();
            wa.delete();
            wd.delete();
            pulse_start();
            for (int i = 0; i < v[k].nb; i++) send(v[k].b[95 - 8*i -: 8]);
            bus.rx_valid = 1'b0;
            wait_end();
            chk($sformatf("v%0d_done", k),     {31'd0, done},       {31'd0, v[k].exp_done});
            chk($sformatf("v%0d_err", k),      {31'd0, err},        {31'd0, v[k].exp_err});
            chk($sformatf("v%0d_cpu_rst", k),  {31'd0, cpu_rst},    {31'd0, !v[k].exp_done});
            chk($sformatf("v%0d_busy", k),     {31'd0, busy},       32'd0);
            chk($sformatf("v%0d_rx_ready", k), {31'd0, bus.rx_ready}, 32'd0);
            chk($sformatf("v%0d_wc", k),       {16'd0, word_count}, {16'd0, v[k].exp_wc});
            chk($sformatf("v%0d_nwrites", k),  wa.size(),           v[k].exp_nw);
            for (int i = 0; i < v[k].exp_nw && i < wa.size(); i++) begin
                chk($sformatf("v%0d_addr%0d", k, i), wa[i], 32'(4 * i));
                chk($sformatf("v%0d_data%0d", k, i), wd[i], (i == 0) ? v[k].w0 : v[k].w1);
            end
        end

        // restart from DONE re-asserts cpu_rst and busy on the next edge
        do_reset();
        pulse_start();
        send(8'h00); send(8'h00); send(8'h00);
        bus.rx_valid = 1'b0;
        wait_end();
        chk("zl_done", {31'd0, done}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_cpu_rst",  {31'd0, cpu_rst},      32'd1);
        chk("restart_busy",     {31'd0, busy},         32'd1);
        chk("restart_done",     {31'd0, done},         32'd0);
        chk("restart_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // length exactly MAX_WORDS is accepted, then reset asynchronously mid-DATA
        send(8'h00); send(8'h01);
        chk("max_len_err",  {31'd0, err},  32'd0);
        chk("max_len_busy", {31'd0, busy}, 32'd1);
        send(8'h78); send(8'h56);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("midreset");
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

`ifdef PROG_LOADER_TIMEOUT_EN
        // 16 idle cycles after the length aborts the load
        do_reset();
        pulse_start();
        send(8'h01); send(8'h00);
        bus.rx_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("tmo15_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("tmo16_err", {31'd0, err}, 32'd1);

        // 15 idle cycles then resume completes the load
        do_reset();
        pulse_start();
        send(8'h01); send(8'h00);
        bus.rx_valid = 1'b0;
        repeat (15) @(negedge clk);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
        bus.rx_valid = 1'b0;
        wait_end();
        chk("tmo_resume_done", {31'd0, done}, 32'd1);
        chk("tmo_resume_wc",   {16'd0, word_count}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
